// File: rtl/delay_sched_pkg.sv
// Shared types, default sizing and the round-robin pick function for the
// delay_scheduler timer-sharing block.
package delay_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int DEF_N       = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_REP_W   = 8;
    localparam int IDX_W       = $clog2(DEF_NUM_REQ);

    // The pick function works on a fixed-width request vector so any
    // requester count up to MAX_REQ can share it.
    localparam int MAX_REQ   = 32;
    localparam int MAX_IDX_W = 5;

    // Returns the first requester at or after ptr (wrapping at num) whose
    // request bit is set; returns ptr when nothing is requesting.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          num
    );
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((i < num) && !found && req[idx[MAX_IDX_W-1:0]]) begin
                rr_pick = idx[MAX_IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pulse_generator.sv
// Free-running period timer: emits a one-cycle pulse every `ticks` enabled
// cycles; ticks == 0 wraps the counter for a period of 2^N.
module pulse_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] ticks,
    output logic         out
);

    logic [N-1:0] cnt_q;
    logic         hit;

    assign hit = (cnt_q == (ticks - N'(1)));
    assign out = ena & hit;

    // NOTE: the clear is synchronous because rst is decoded from FSM state
    // and must never reach an asynchronous pin where a glitch could fire it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ena) begin
            cnt_q <= hit ? '0 : cnt_q + N'(1);
        end
    end

endmodule

// File: rtl/delay_scheduler.sv
// Round-robin owner of a single pulse_generator: grants it to one requester,
// counts `reps` periods of `ticks` clocks and returns a one-cycle done.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int REP_W   = DEF_REP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*N-1:0]     req_ticks,
    input  logic [NUM_REQ*REP_W-1:0] req_reps,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     tick
);

    localparam int OWN_W = $clog2(NUM_REQ);

    sched_state_t     state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]     ticks_q, ticks_d;
    logic [REP_W-1:0] reps_left_q, reps_left_d;

    logic [OWN_W-1:0] pick_idx;
    logic [OWN_W-1:0] next_ptr;
    logic             owner_req;
    logic             pg_rst;
    logic             pg_ena;
    logic             pg_out;

    assign pick_idx  = OWN_W'(rr_pick(MAX_REQ'(req), MAX_IDX_W'(rr_ptr_q), NUM_REQ));
    assign next_ptr  = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
    assign owner_req = req[owner_q];

    // Counter is held clear in every state but RUN, which covers the LOAD
    // cycle and guarantees each grant starts from a fresh period.
    assign pg_rst = ~rst | (state_q != RUN);
    assign pg_ena = (state_q == RUN);

    pulse_generator #(
        .N(N)
    ) u_pg (
        .clk  (clk),
        .rst  (pg_rst),
        .ena  (pg_ena),
        .ticks(ticks_q),
        .out  (pg_out)
    );

    // NOTE: every next-state variable is given its current value first, so
    // no branch of the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        ticks_d     = ticks_q;
        reps_left_d = reps_left_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d     = pick_idx;
                    ticks_d     = req_ticks[pick_idx*N +: N];
                    reps_left_d = req_reps[pick_idx*REP_W +: REP_W];
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (!owner_req) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (reps_left_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (pg_out) begin
                    if (reps_left_q != '0) begin
                        reps_left_d = reps_left_q - REP_W'(1);
                    end
                    if (reps_left_q <= REP_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of all the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            ticks_q     <= '0;
            reps_left_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            ticks_q     <= ticks_d;
            reps_left_q <= reps_left_d;
        end
    end

    always_comb begin
        grant = '0;
        done  = '0;
        busy  = (state_q != IDLE);
        tick  = pg_out & (state_q == RUN);
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = busy && (owner_q == OWN_W'(i));
            done[i]  = (state_q == DONE) && (owner_q == OWN_W'(i));
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler: every grant is measured against a
// transaction-level model (owner order, length, tick spacing, done timing).
module tb_delay_scheduler;

    localparam int N       = 8;
    localparam int NUM_REQ = 4;
    localparam int REP_W   = 8;
    localparam int BUDGET  = 2000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*N-1:0]     req_ticks;
    logic [NUM_REQ*REP_W-1:0] req_reps;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     tick;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    delay_scheduler #(
        .N(N),
        .NUM_REQ(NUM_REQ),
        .REP_W(REP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_ticks(req_ticks),
        .req_reps (req_reps),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .tick     (tick)
    );

    // First requester at or after ptr, counting around the ring.
    function automatic int model_pick(input logic [NUM_REQ-1:0] rv, input int ptr);
        int idx;
        model_pick = -1;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (ptr + k) % NUM_REQ;
            if (rv[idx]) model_pick = idx;
        end
    endfunction

    task automatic set_slice(input int i, input int t, input int r);
        req_ticks[i*N +: N]         = N'(t);
        req_reps[i*REP_W +: REP_W]  = REP_W'(r);
    endtask

    task automatic rand_slices();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_slice(i, int'($urandom_range(6, 1)), int'($urandom_range(3, 0)));
        end
    endtask

    // Follows one grant from its first cycle to the following idle cycle.
    task automatic observe_grant(input int exp_owner, input int t, input int r,
                                 input int abort_k, input int mutate_c);
        int p, exp_len, exp_ticks, exp_done_at;
        int cyc, n_tick, tick_bad, n_done, done_at, grant_bad, done_bad, busy_bad;
        logic [NUM_REQ-1:0] exp_g;
        p     = (t == 0) ? (1 << N) : t;
        exp_g = NUM_REQ'(1) << exp_owner;
        if (abort_k >= 0) begin
            exp_len     = abort_k + 1;
            exp_ticks   = abort_k / p;
            exp_done_at = 0;
        end else begin
            exp_len     = 2 + p * r;
            exp_ticks   = r;
            exp_done_at = exp_len;
        end
        cyc = 0; n_tick = 0; tick_bad = 0; n_done = 0; done_at = 0;
        grant_bad = 0; done_bad = 0; busy_bad = 0;

        @(negedge clk);
        n_cmp++;
        if (grant !== exp_g) begin
            n_bad++;
            $display("FAIL grant_latency: grant=%b expected=%b", grant, exp_g);
        end

        while (grant !== '0 && cyc < BUDGET) begin
            cyc++;
            if (grant !== exp_g) grant_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (tick === 1'b1) begin
                n_tick++;
                if (cyc < 2 || ((cyc - 1) % p) != 0) tick_bad++;
            end
            if (done !== '0) begin
                n_done++;
                done_at = cyc;
                if (done !== exp_g) done_bad++;
            end
            if (cyc == mutate_c) begin
                rand_slices();
                req = (req & exp_g) | (NUM_REQ'($urandom) & ~exp_g);
            end
            if (abort_k >= 0 && cyc == abort_k + 1) req[exp_owner] = 1'b0;
            @(negedge clk);
        end

        n_cmp++;
        if (cyc >= BUDGET) begin
            n_bad++;
            $display("FAIL grant_timeout: grant still %b after %0d cycles", grant, cyc);
        end
        n_cmp++;
        if (cyc != exp_len) begin
            n_bad++;
            $display("FAIL grant_len owner %0d: got %0d cycles, expected %0d", exp_owner, cyc, exp_len);
        end
        n_cmp++;
        if (grant_bad != 0 || busy_bad != 0) begin
            n_bad++;
            $display("FAIL grant_stable: %0d grant / %0d busy bad cycles, expected 0", grant_bad, busy_bad);
        end
        n_cmp++;
        if (n_tick != exp_ticks) begin
            n_bad++;
            $display("FAIL tick_count: got %0d, expected %0d (t=%0d r=%0d)", n_tick, exp_ticks, t, r);
        end
        n_cmp++;
        if (tick_bad != 0) begin
            n_bad++;
            $display("FAIL tick_spacing: %0d misplaced ticks, expected 0 (period %0d)", tick_bad, p);
        end
        n_cmp++;
        if (n_done != (abort_k >= 0 ? 0 : 1) || done_at != exp_done_at || done_bad != 0) begin
            n_bad++;
            $display("FAIL done_pulse: count=%0d at=%0d bad=%0d, expected count=%0d at=%0d",
                     n_done, done_at, done_bad, (abort_k >= 0 ? 0 : 1), exp_done_at);
        end
        n_cmp++;
        if ({busy, done, tick} !== '0) begin
            n_bad++;
            $display("FAIL idle_after: busy=%b done=%b tick=%b, expected all 0", busy, done, tick);
        end
        ptr_m = (exp_owner + 1) % NUM_REQ;
    endtask

    // Drives a request vector from IDLE and checks the grant it produces.
    // abort_k: -1 none, -2 random, else RUN cycle after which the owner drops.
    task automatic run_txn(input logic [NUM_REQ-1:0] rv, input int abort_k, input int mutate_c);
        int owner, t, r, p, k;
        req   = rv;
        owner = model_pick(rv, ptr_m);
        t     = int'(req_ticks[owner*N +: N]);
        r     = int'(req_reps[owner*REP_W +: REP_W]);
        p     = (t == 0) ? (1 << N) : t;
        k     = abort_k;
        if (k == -2) k = (p * r > 0) ? int'($urandom_range(p * r - 1, 0)) : -1;
        observe_grant(owner, t, r, k, mutate_c);
        req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 1, 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({grant, done, busy, tick} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: grant=%b done=%b busy=%b tick=%b, expected 0",
                     grant, done, busy, tick);
        end
        rst   = 1'b1;
        ptr_m = 0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 1, 1);
        for (int n = 0; n < 5; n++) run_txn(4'b1111, -1, -1);
    endtask

    task automatic test_single();
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 1, 1);
        set_slice(2, 3, 2);
        run_txn(4'b0100, -1, -1);
        run_txn(4'b1111, -1, -1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 2, 1);
        set_slice(1, 5, 4);
        run_txn(4'b0010, 7, 3);
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 2, 1);
        run_txn(4'b0101, -1, -1);
    endtask

    task automatic test_edge_counts();
        set_slice(0, 5, 0);
        run_txn(4'b0001, -1, -1);
        set_slice(1, 0, 1);
        run_txn(4'b0010, -1, -1);
        set_slice(3, 1, 0);
        run_txn(4'b1000, -1, -1);
    endtask

    task automatic test_async_reset();
        int owner;
        set_slice(2, 1, 1);
        run_txn(4'b0100, -1, -1);
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 10, 5);
        req   = 4'b1111;
        owner = model_pick(req, ptr_m);
        @(negedge clk);
        n_cmp++;
        if (grant !== NUM_REQ'(1) << owner) begin
            n_bad++;
            $display("FAIL pre_reset_grant: grant=%b expected owner %0d", grant, owner);
        end
        repeat (6) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({grant, done, busy, tick} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: grant=%b done=%b busy=%b tick=%b, expected 0",
                     grant, done, busy, tick);
        end
        @(negedge clk);
        n_cmp++;
        if ({grant, done, busy, tick} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: grant=%b done=%b busy=%b tick=%b, expected 0",
                     grant, done, busy, tick);
        end
        rst   = 1'b1;
        ptr_m = 0;
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 2, 1);
        run_txn(4'b1111, -1, -1);
    endtask

    task automatic test_nonowner();
        for (int i = 0; i < NUM_REQ; i++) set_slice(i, 1, 1);
        set_slice(0, 7, 3);
        run_txn(4'b0001, -1, 3);
        run_txn(4'b0001, -1, -1);
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] rv;
        for (int n = 0; n < 40; n++) begin
            rand_slices();
            rv = NUM_REQ'($urandom_range(15, 1));
            run_txn(rv, ($urandom_range(3, 0) == 0) ? -2 : -1, int'($urandom_range(4, 1)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_abort();
        test_edge_counts();
        test_async_reset();
        test_nonowner();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Shares one `pulse_generator` timebase among `NUM_REQ` requesters that each need a timed delay of `reps` periods of `ticks` clocks (LED refresh, debounce, SPI inter-frame gaps). A round-robin arbiter grants the timer to one requester at a time, loads its period, counts completed periods, and returns a one-cycle `done` to the owner. Sits between the requester FSMs and a single private `pulse_generator` instance.

## Interface
- `N`, 8, width of the tick period
- `NUM_REQ`, 4, number of requesters (≥2)
- `REP_W`, 8, width of the repetition count
- `clk` input 1 system clock, rising edge
- `rst` input 1 asynchronous, active-low reset (low = reset)
- `req` input NUM_REQ level request per requester; held until `done` or dropped to abort
- `req_ticks` input NUM_REQ*N period per requester, slice i = [i*N +: N]
- `req_reps` input NUM_REQ*REP_W periods per requester, slice i = [i*REP_W +: REP_W]
- `grant` output NUM_REQ one-hot owner, all-zero when idle
- `done` output NUM_REQ one-cycle completion pulse to owner
- `busy` output 1 high in any state other than IDLE
- `tick` output 1 timebase pulse, gated to RUN

## Operation
- States: IDLE, LOAD, RUN, DONE (registered FSM).
- IDLE: if any `req` is high, pick the first requester at or after `rr_ptr` (wrapping) and latch its index, `req_ticks` slice into `ticks_q`, and `req_reps` slice into `reps_left`. Then go to LOAD. Otherwise stay.
- LOAD: hold the pulse_generator in its local clear for one cycle. If `reps_left==0`, go to DONE; else go to RUN.
- RUN: pulse_generator `ena=1`, period `ticks_q`. Each `pg_out` pulse drives `tick` and decrements `reps_left`. A pulse with `reps_left==1` goes to DONE.
- DONE: `done[owner]=1` for exactly one cycle. Set `rr_ptr ← owner+1`, wrapping at NUM_REQ-1→0. Go to IDLE.
- Abort: if `req[owner]` drops in LOAD or RUN, go to IDLE next cycle. No `done` is issued, and `rr_ptr` still advances past the owner.
- `req` changes from non-owners never affect the current owner. Their slices are not sampled until the next IDLE.
- `ticks_q==1` gives a pulse every RUN cycle. `ticks_q==0` gives a period of 2^N cycles (counter wrap).
- Width rules: `reps_left` is REP_W wide, decrements by 1, and never underflows.
- `grant`, `done`, `busy` and `tick` are decoded from registered state, owner and `pg_out` only. They do not depend combinationally on `req`.

## Timing
- Reset (`rst` low, asynchronous): state=IDLE, `rr_ptr`=0, `reps_left`=0, `ticks_q`=0. All outputs are 0 and the pulse_generator counter is held cleared. Reset mid-RUN aborts immediately with no `done`.
- Request-to-grant latency: `req` high in IDLE at edge k gives `grant` high from cycle k+1 (LOAD).
- `grant[owner]` is high through LOAD, RUN and DONE, for exactly 2 + ticks·reps cycles when ticks ≥ 1.
- The first `tick` occurs in the ticks-th RUN cycle. Subsequent ticks are every `ticks` cycles.
- `done` coincides with the last `grant` cycle. IDLE follows, so back-to-back grants have at least one idle cycle between them.
- `reps==0`: `grant` lasts 2 cycles (LOAD, DONE), with no `tick`.

## Structure
- Package `delay_sched_pkg` holds:
  - `sched_state_t` enum {IDLE, LOAD, RUN, DONE}
  - localparam `IDX_W = $clog2(NUM_REQ)`
  - the round-robin pick function.
- One instance of the existing `pulse_generator` sub-module:
  - `rst = ~rst | (state==LOAD) | (state!=RUN)`
  - `ena = (state==RUN)`
  - `ticks = ticks_q`
- No other sub-modules. The arbiter is a function in the package.

## Test plan
- Single request: req[2]=1, ticks=3, reps=2 → `grant`=4'b0100 for 8 cycles; `tick` in RUN cycles 3 and 6; `done[2]` in cycle 8; `rr_ptr`=3.
- Fairness: all `req`=4'b1111 held, ticks=1, reps=1 → grants in order 0,1,2,3,0, each lasting 3 cycles with 1 IDLE gap; each `done` fires once per grant.
- Abort: req[1] runs ticks=5, reps=4; drop req[1] after 7 RUN cycles → IDLE next cycle, no `done`, next grant goes to requester 2 if requesting.
- Edge counts: reps=0 → `grant` for 2 cycles with `done` in the second and no `tick`. ticks=0, N=4, reps=1 → first `tick` after 16 RUN cycles.
- Async reset mid-RUN: pull `rst` low between edges → outputs 0 immediately. After release, re-request of requester 0 is granted from IDLE with `rr_ptr`=0.
- Non-owner stability: change req_ticks[0] while requester 0 owns the timer → period unchanged until the next grant.
